// File: rtl/home_auto_pkg.sv
// home_auto_pkg
//   Shared definitions for the home-automation button front end.
//   - 2-bit state encodings for the debounce FSM (as localparams, and an
//     enum built from them so the FSM gets readable state names)
//   - default timing constants for debounce and long-press detection
//   - params_ok(): legality check for the debounce/long-press parameters
package home_auto_pkg;

  localparam logic [1:0] ST_IDLE         = 2'b00;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'b01;
  localparam logic [1:0] ST_HELD         = 2'b10;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'b11;

  typedef enum logic [1:0] {
    IDLE         = ST_IDLE,
    PRESS_WAIT   = ST_PRESS_WAIT,
    HELD         = ST_HELD,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES   = 16;
  localparam int DEF_LONG_PRESS_CYCLES = 64;

  // The long press must outlast the debounce window, and a one-sample
  // debounce would defeat the purpose of the filter.
  function automatic bit params_ok(input int debounce_cycles,
                                   input int long_press_cycles);
    return (debounce_cycles >= 2) && (long_press_cycles > debounce_cycles);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level.
//   Ports:
//     clk   - destination clock
//     rst_n - asynchronous active-low reset, clears both flops
//     d     - asynchronous input
//     q     - synchronized output (two clk edges of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/button_toggle_debounce.sv
// button_toggle_debounce
//   Debounces a raw pushbutton and produces strobes for a downstream
//   toggle flop plus a long-press event.
//   Parameters:
//     DEBOUNCE_CYCLES   - stable synchronized samples needed to accept a change
//     LONG_PRESS_CYCLES - cycles a press is held before long_pulse fires
//   Ports:
//     clk        - single clock, rising edge
//     rst_n      - asynchronous active-low reset
//     btn_raw    - raw active-high button, asynchronous and bouncy
//     t_pulse    - one-cycle strobe per accepted press (feeds t_ff.t)
//     long_pulse - one-cycle strobe once per press held long enough
//     btn_level  - debounced button level
module button_toggle_debounce
  import home_auto_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic t_pulse,
  output logic long_pulse,
  output logic btn_level
);

  if (!params_ok(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)) begin : g_param_check
    $error("button_toggle_debounce: need DEBOUNCE_CYCLES>=2 and LONG_PRESS_CYCLES>DEBOUNCE_CYCLES");
  end

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic btn_sync;

  btn_state_e        state_reg,      state_next;
  logic [DB_W-1:0]   db_cnt_reg,     db_cnt_next;
  logic [HOLD_W-1:0] hold_cnt_reg,   hold_cnt_next;
  logic              t_pulse_reg,    t_pulse_next;
  logic              long_pulse_reg, long_pulse_next;
  logic              btn_level_reg,  btn_level_next;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      db_cnt_reg     <= '0;
      hold_cnt_reg   <= '0;
      t_pulse_reg    <= 1'b0;
      long_pulse_reg <= 1'b0;
      btn_level_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      db_cnt_reg     <= db_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      t_pulse_reg    <= t_pulse_next;
      long_pulse_reg <= long_pulse_next;
      btn_level_reg  <= btn_level_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    db_cnt_next     = db_cnt_reg;
    hold_cnt_next   = hold_cnt_reg;
    t_pulse_next    = 1'b0;
    long_pulse_next = 1'b0;
    btn_level_next  = btn_level_reg;

    // Hold time keeps running through a release bounce. Saturating at the
    // last value means the long-press strobe can only fire once per press.
    if ((state_reg == HELD || state_reg == RELEASE_WAIT) &&
        (hold_cnt_reg != HOLD_LAST)) begin
      hold_cnt_next   = hold_cnt_reg + 1'b1;
      long_pulse_next = (hold_cnt_reg == HOLD_LAST - 1'b1);
    end

    unique case (state_reg)
      IDLE: begin
        if (btn_sync) begin
          state_next  = PRESS_WAIT;
          db_cnt_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_next = IDLE;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next     = HELD;
          t_pulse_next   = 1'b1;
          btn_level_next = 1'b1;
          hold_cnt_next  = '0;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_next  = RELEASE_WAIT;
          db_cnt_next = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_next = HELD;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next     = IDLE;
          btn_level_next = 1'b0;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign t_pulse    = t_pulse_reg;
  assign long_pulse = long_pulse_reg;
  assign btn_level  = btn_level_reg;

endmodule
